// File: rtl/button_event_scheduler_pkg.sv
// Shared types, default constants and the round-robin pick function
// used by the button event scheduler.
`timescale 1ns/1ps
package btn_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_N_BTN        = 4;
  localparam int unsigned DEF_TICK_DIV     = 250000;
  localparam int unsigned DEF_DEBOUNCE_LEN = 4;

  // Widest button vector and id the pick function handles.
  localparam int unsigned MAX_BTN = 8;
  localparam int unsigned PICK_W  = 3;

  // First set bit of req[n-1:0] scanning upward from ptr, wrapping at n.
  // Returns 0 when nothing is requested; callers only use it when req != 0.
  function automatic logic [PICK_W-1:0] rr_pick(
    input logic [MAX_BTN-1:0] req,
    input logic [PICK_W-1:0]  ptr,
    input int unsigned        n
  );
    logic [PICK_W-1:0] sel;
    logic              found;
    int unsigned       idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_BTN; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !found && req[PICK_W'(idx)]) begin
        sel   = PICK_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// Valid/ready event channel carrying the id of the pressed button.
`timescale 1ns/1ps
interface button_event_scheduler_if
  import btn_sched_pkg::*;
#(
  parameter int unsigned ID_W = $clog2(DEF_N_BTN)
) ();

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );

endinterface

// File: rtl/button_event_scheduler_tick_gen.sv
// Free-running divider: tick is high for one in_clk cycle every TICK_DIV cycles.
`timescale 1ns/1ps
module tick_gen
  import btn_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic in_clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] tick_cnt;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and wrap.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Push-button front end: synchronise, debounce on a slow tick, turn each
// debounced press into a pending event and grant events round-robin to a
// single valid/ready consumer.
`timescale 1ns/1ps
module button_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter int unsigned N_BTN        = DEF_N_BTN,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned DEBOUNCE_LEN = DEF_DEBOUNCE_LEN,
  parameter int unsigned ID_W         = $clog2(N_BTN)
) (
  input  logic                     in_clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         pb,
  output logic [N_BTN-1:0]         btn_level,
  output logic [N_BTN-1:0]         overrun,
  button_event_scheduler_if.master evt
);

  logic [N_BTN-1:0] sync_q;
  logic [N_BTN-1:0] pb_s;
  logic             tick;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] grant;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  ptr_next;
  logic             take;
  logic             done;
  arb_state_t       state;
  arb_state_t       state_next;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      pb_s   <= '0;
    end else begin
      sync_q <= pb;
      pb_s   <= sync_q;
    end
  end

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .in_clk (in_clk),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  // Per-button debounce. Only the DEBOUNCE_LEN-1 most recent samples are
  // stored: the oldest bit of a full-width shift register would be shifted
  // out before it is ever examined, so the window is rebuilt from the
  // history plus the current sample with identical behaviour.
  for (genvar i = 0; i < N_BTN; i++) begin : g_deb
    logic [DEBOUNCE_LEN-2:0] hist;
    logic [DEBOUNCE_LEN-1:0] window;
    logic                    level;

    assign window       = {hist, pb_s[i]};
    assign press[i]     = tick & (&window) & ~level;
    assign btn_level[i] = level;

    // Shift a sample in on each tick; change level on a full run of equal samples.
    always_ff @(posedge in_clk or negedge rst_n) begin
      if (!rst_n) begin
        hist  <= '0;
        level <= 1'b0;
      end else if (tick) begin
        hist <= window[DEBOUNCE_LEN-2:0];
        if (&window) begin
          level <= 1'b1;
        end else if (~|window) begin
          level <= 1'b0;
        end
      end
    end
  end

  assign pick     = ID_W'(rr_pick(MAX_BTN'(pending), PICK_W'(rr_ptr), N_BTN));
  assign ptr_next = (evt.evt_id == ID_W'(N_BTN - 1)) ? '0 : evt.evt_id + 1'b1;

  // Arbiter state register.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbiter next state: grant a pending button from IDLE, wait for the handshake in OFFER.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    done       = 1'b0;
    grant      = '0;
    unique case (state)
      ST_IDLE: begin
        if (|pending) begin
          take       = 1'b1;
          grant      = N_BTN'(1) << pick;
          state_next = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt.evt_valid && evt.evt_ready) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Offer registers: id/valid held stable until the consumer accepts.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      evt.evt_valid <= 1'b0;
      evt.evt_id    <= '0;
      rr_ptr        <= '0;
    end else if (take) begin
      evt.evt_valid <= 1'b1;
      evt.evt_id    <= pick;
    end else if (done) begin
      evt.evt_valid <= 1'b0;
      rr_ptr        <= ptr_next;
    end
  end

  // Pending set/clear; a new press wins over a same-cycle grant and merges
  // into an already pending press, flagging the loss.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~grant) | press;
      overrun <= press & pending & ~grant;
    end
  end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench for button_event_scheduler (N_BTN=4, TICK_DIV=4,
// DEBOUNCE_LEN=3) against an event-level reference model.
`timescale 1ns/1ps
module tb_button_event_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned TD  = 4;
  localparam int unsigned DL  = 3;
  localparam int unsigned IDW = 2;

  logic       in_clk = 1'b0;
  logic       rst_n  = 1'b1;
  logic [3:0] pb     = 4'h0;
  logic [3:0] btn_level;
  logic [3:0] overrun;

  button_event_scheduler_if #(.ID_W(IDW)) evt ();

  button_event_scheduler #(
    .N_BTN        (N),
    .TICK_DIV     (TD),
    .DEBOUNCE_LEN (DL),
    .ID_W         (IDW)
  ) dut (
    .in_clk    (in_clk),
    .rst_n     (rst_n),
    .pb        (pb),
    .btn_level (btn_level),
    .overrun   (overrun),
    .evt       (evt)
  );

  always #1 in_clk = ~in_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  // Reference model: counts since reset, a 2-deep input history, runs of
  // equal tick samples per button, pending flags and the current offer.
  logic [3:0]  m_level, m_pending, m_overrun, m_h1, m_h2, m_run_val;
  int unsigned m_run_len [4];
  int unsigned m_cyc, m_id, m_ptr;
  logic        m_offer;

  // Observations collected while stepping.
  int          ev_ids [$];
  int unsigned ev_cyc [$];
  int          exp_q  [$];
  int unsigned cyc_no   = 0;
  int unsigned ovr_cnt  = 0;
  logic [3:0]  ovr_seen = 4'h0;
  int unsigned rise0    = 0;
  logic [3:0]  prev_level = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level   = '0;
    m_pending = '0;
    m_overrun = '0;
    m_h1      = '0;
    m_h2      = '0;
    m_run_val = '0;
    for (int i = 0; i < 4; i++) m_run_len[i] = DL;
    m_cyc   = 0;
    m_id    = 0;
    m_ptr   = 0;
    m_offer = 1'b0;
  endtask

  // Predict the state after the coming rising edge from the inputs now applied.
  task automatic model_advance();
    logic [3:0] press;
    logic [3:0] grant;
    int unsigned idx;
    press = '0;
    grant = '0;
    if (m_cyc % TD == TD - 1) begin
      for (int i = 0; i < 4; i++) begin
        if (m_h2[i] == m_run_val[i]) begin
          if (m_run_len[i] < DL) m_run_len[i]++;
        end else begin
          m_run_val[i] = m_h2[i];
          m_run_len[i] = 1;
        end
        if (m_run_len[i] >= DL) begin
          if (m_run_val[i] && !m_level[i]) press[i] = 1'b1;
          m_level[i] = m_run_val[i];
        end
      end
    end
    if (m_offer) begin
      if (evt.evt_ready) begin
        m_ptr   = (m_id + 1) % N;
        m_offer = 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % N;
        if (!m_offer && ((m_pending >> idx) & 4'h1) != 4'h0) begin
          m_id    = idx;
          m_offer = 1'b1;
          grant   = 4'h1 << idx;
        end
      end
    end
    m_overrun = press & m_pending & ~grant;
    m_pending = (m_pending & ~grant) | press;
    m_h2  = m_h1;
    m_h1  = pb;
    m_cyc++;
  endtask

  // One clock: compare outputs at the falling edge, then apply new inputs.
  task automatic step(input logic [3:0] pbv, input logic rdy, input logic rstv);
    @(negedge in_clk);
    cyc_no++;
    check("btn_level", 32'(btn_level), 32'(m_level));
    check("evt_valid", 32'(evt.evt_valid), 32'(m_offer));
    if (m_offer) check("evt_id", 32'(evt.evt_id), m_id);
    check("overrun", 32'(overrun), 32'(m_overrun));
    if (overrun != 4'h0) ovr_cnt++;
    ovr_seen = ovr_seen | overrun;
    if (btn_level[0] && !prev_level[0]) rise0++;
    prev_level = btn_level;
    rst_n         = rstv;
    pb            = pbv;
    evt.evt_ready = rdy;
    if (!rst_n) model_reset();
    else        model_advance();
    if (rst_n && evt.evt_valid && rdy) begin
      ev_ids.push_back(int'(evt.evt_id));
      ev_cyc.push_back(cyc_no);
    end
  endtask

  task automatic run(input int unsigned n, input logic [3:0] pbv, input logic rdy);
    for (int unsigned c = 0; c < n; c++) step(pbv, rdy, 1'b1);
  endtask

  task automatic check_ids(input string tag);
    check({tag, "_count"}, ev_ids.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_ids.size(); i++)
      check(tag, ev_ids[i], exp_q[i]);
  endtask

  task automatic clear_obs();
    ev_ids.delete();
    ev_cyc.delete();
    ovr_cnt  = 0;
    ovr_seen = 4'h0;
    rise0    = 0;
  endtask

  logic [3:0] cur;

  initial begin
    model_reset();
    evt.evt_ready = 1'b0;
    pb            = 4'hF;
    rst_n         = 1'b0;

    // Reset with all buttons held
    for (int c = 0; c < 3; c++) step(4'hF, 1'b0, 1'b0);
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_valid", 32'(evt.evt_valid), 32'h0);
    check("rst_id", 32'(evt.evt_id), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    // Release reset with all buttons pressed: events 0,1,2,3
    clear_obs();
    run(40, 4'hF, 1'b1);
    check("all_level", 32'(btn_level), 32'hF);
    exp_q = '{0, 1, 2, 3};
    check_ids("all_ids");
    run(30, 4'h0, 1'b1);

    // Bouncing button 0
    clear_obs();
    for (int c = 0; c < 40; c++) step({3'b000, ((c / 3) % 2) == 0}, 1'b1, 1'b1);
    run(30, 4'h1, 1'b1);
    exp_q = '{0};
    check_ids("bounce_ids");
    check("bounce_rises", rise0, 1);
    check("bounce_overrun", ovr_cnt, 0);
    run(30, 4'h0, 1'b1);

    // Round robin from a fresh pointer
    for (int c = 0; c < 2; c++) step(4'h0, 1'b1, 1'b0);
    clear_obs();
    run(30, 4'h7, 1'b1);
    exp_q = '{0, 1, 2};
    check_ids("rr_ids");
    if (ev_cyc.size() >= 3) begin
      check("rr_gap01", ev_cyc[1] - ev_cyc[0], 2);
      check("rr_gap12", ev_cyc[2] - ev_cyc[1], 2);
    end
    run(30, 4'h0, 1'b1);
    clear_obs();
    run(30, 4'h9, 1'b1);
    exp_q = '{3, 0};
    check_ids("rr_wrap_ids");
    run(30, 4'h0, 1'b1);

    // Backpressure, re-press while offered, then overrun
    clear_obs();
    run(20, 4'h2, 1'b0);
    run(20, 4'h2, 1'b0);
    check("bp_hold_valid", 32'(evt.evt_valid), 32'h1);
    check("bp_hold_id", 32'(evt.evt_id), 32'h1);
    run(25, 4'h0, 1'b0);
    run(20, 4'h2, 1'b0);
    check("bp_second_no_ovr", ovr_cnt, 0);
    run(25, 4'h0, 1'b0);
    run(20, 4'h2, 1'b0);
    check("bp_ovr_pulses", ovr_cnt, 1);
    check("bp_ovr_bits", 32'(ovr_seen), 32'h2);
    run(10, 4'h2, 1'b1);
    exp_q = '{1, 1};
    check_ids("bp_ids");
    run(25, 4'h0, 1'b1);

    // Reset in the middle of an offer
    run(20, 4'h1, 1'b0);
    check("mid_valid_before", 32'(evt.evt_valid), 32'h1);
    step(4'h0, 1'b0, 1'b0);
    #0.5;
    check("mid_async_drop", 32'(evt.evt_valid), 32'h0);
    clear_obs();
    run(30, 4'h0, 1'b1);
    check("mid_no_events", ev_ids.size(), 0);

    // Randomised buttons and consumer readiness
    cur = 4'h0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      step(cur, 1'($urandom_range(0, 1)), 1'b1);
    end
    run(4, 4'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
